// File: rtl/lsnn_array.sv
// N-neuron adaptive leaky integrate-and-fire array. One shared update datapath
// is time-multiplexed over the neurons, one neuron per cycle after each step_i.
module lsnn_array #(
   parameter int W              = 8,
   parameter int N              = 4,
   parameter int DECAY_SHIFT    = 1,
   parameter int ADAPT_UP_SHIFT = 2,
   parameter int ALPHA_INC      = 1,
   parameter int ALPHA0         = 8,
   parameter int B0             = 8,
   parameter int REFRAC         = 2,
   parameter int IDXW           = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            step_i,
   input  logic [N*W-1:0]  in_cur_i,
   output logic            busy_o,
   output logic            done_o,
   output logic [N-1:0]    spikes_o,
   output logic            overrun_o,
   input  logic [IDXW-1:0] rd_sel_i,
   output logic [W-1:0]    thr_o,
   output logic [W-1:0]    vmem_o
);

   localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
   localparam logic [W+1:0]  MAXV     = {2'b00, {W{1'b1}}};
   localparam logic [W-1:0]  B0_W     = W'(B0);
   localparam logic [W-1:0]  ALPHA0_W = W'(ALPHA0);
   localparam logic [W+1:0]  INC_W2   = (W+2)'(ALPHA_INC);
   localparam logic [RW-1:0] REFRAC_W = RW'(REFRAC);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_UPDATE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   // Clamp a widened sum back into the W-bit unsigned range.
   function automatic logic [W-1:0] sat(input logic [W+1:0] x);
      if (x > MAXV) begin
         return MAXV[W-1:0];
      end else begin
         return x[W-1:0];
      end
   endfunction

   state_t          state_q, state_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [N*W-1:0]  cur_q, cur_d;
   logic [W-1:0]    v_q [N];
   logic [W-1:0]    v_d [N];
   logic [W-1:0]    a_q [N];
   logic [W-1:0]    a_d [N];
   logic [RW-1:0]   rf_q [N];
   logic [RW-1:0]   rf_d [N];
   logic [N-1:0]    shadow_q, shadow_d;
   logic [N-1:0]    spikes_q, spikes_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            overrun_q, overrun_d;
   logic [W-1:0]    thr_q, thr_d;
   logic [W-1:0]    vmem_q, vmem_d;

   logic [W-1:0]    cur_k, v_k, a_k, thr_k, vn_k, a_up_k, a_dec_k;
   logic [RW-1:0]   rf_k;
   logic            fire_k;

   // Shared neuron datapath for the neuron selected by idx_q.
   always_comb begin
      cur_k   = cur_q[int'(idx_q)*W +: W];
      v_k     = v_q[idx_q];
      a_k     = a_q[idx_q];
      rf_k    = rf_q[idx_q];
      thr_k   = sat({2'b00, B0_W} + {2'b00, a_k});
      vn_k    = sat({2'b00, cur_k} + ({2'b00, v_k} >> DECAY_SHIFT));
      a_up_k  = sat({2'b00, a_k} + ({2'b00, a_k} >> ADAPT_UP_SHIFT) + INC_W2);
      a_dec_k = (a_k >> 1) + (a_k >> 2);
      fire_k  = (rf_k == {RW{1'b0}}) && (vn_k >= thr_k);
   end

   // Sequencer and per-neuron state update; step_i outside IDLE only flags overrun.
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cur_d     = cur_q;
      v_d       = v_q;
      a_d       = a_q;
      rf_d      = rf_q;
      shadow_d  = shadow_q;
      spikes_d  = spikes_q;
      done_d    = 1'b0;
      overrun_d = overrun_q;
      case (state_q)
         S_IDLE: begin
            if (step_i) begin
               cur_d   = in_cur_i;
               idx_d   = {IDXW{1'b0}};
               state_d = S_UPDATE;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_UPDATE: begin
            if (rf_k != {RW{1'b0}}) begin
               v_d[idx_q]      = {W{1'b0}};
               rf_d[idx_q]     = rf_k - RW'(1);
               a_d[idx_q]      = a_dec_k;
               shadow_d[idx_q] = 1'b0;
            end else if (fire_k) begin
               v_d[idx_q]      = {W{1'b0}};
               rf_d[idx_q]     = REFRAC_W;
               a_d[idx_q]      = a_up_k;
               shadow_d[idx_q] = 1'b1;
            end else begin
               v_d[idx_q]      = vn_k;
               a_d[idx_q]      = a_dec_k;
               shadow_d[idx_q] = 1'b0;
            end
            if (step_i) begin
               overrun_d = 1'b1;
            end else begin
               overrun_d = overrun_q;
            end
            if (idx_q == IDXW'(N - 1)) begin
               state_d = S_DONE;
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         S_DONE: begin
            spikes_d = shadow_q;
            done_d   = 1'b1;
            state_d  = S_IDLE;
            if (step_i) begin
               overrun_d = 1'b1;
            end else begin
               overrun_d = overrun_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // Readback samples committed state every cycle, so it tracks a step in progress.
   always_comb begin
      if (int'(rd_sel_i) < N) begin
         thr_d  = sat({2'b00, B0_W} + {2'b00, a_q[rd_sel_i]});
         vmem_d = v_q[rd_sel_i];
      end else begin
         thr_d  = {W{1'b0}};
         vmem_d = {W{1'b0}};
      end
   end

   // State registers; rst_n is the active-high asynchronous reset of this codebase.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q   <= S_IDLE;
         idx_q     <= {IDXW{1'b0}};
         cur_q     <= {(N*W){1'b0}};
         for (int k = 0; k < N; k++) begin
            v_q[k]  <= {W{1'b0}};
            a_q[k]  <= ALPHA0_W;
            rf_q[k] <= {RW{1'b0}};
         end
         shadow_q  <= {N{1'b0}};
         spikes_q  <= {N{1'b0}};
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         overrun_q <= 1'b0;
         thr_q     <= sat({2'b00, B0_W} + {2'b00, ALPHA0_W});
         vmem_q    <= {W{1'b0}};
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cur_q     <= cur_d;
         v_q       <= v_d;
         a_q       <= a_d;
         rf_q      <= rf_d;
         shadow_q  <= shadow_d;
         spikes_q  <= spikes_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         overrun_q <= overrun_d;
         thr_q     <= thr_d;
         vmem_q    <= vmem_d;
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign spikes_o  = spikes_q;
   assign overrun_o = overrun_q;
   assign thr_o     = thr_q;
   assign vmem_o    = vmem_q;

endmodule
